// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register bank.
package spi_reg_pkg;

  // Register map
  localparam int ADDR_STATUS = 0;
  localparam int ADDR_CTRL   = 1;
  localparam int ADDR_P      = 2;
  localparam int ADDR_E      = 3;
  localparam int ADDR_M      = 4;
  localparam int ADDR_CONST  = 5;
  localparam int ADDR_C      = 6;
  localparam int ADDR_SPARE  = 7;

  // Command byte layout and control register bits
  localparam int CMD_BITS       = 8;
  localparam int CMD_RW_BIT     = 7;
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_STOP_BIT  = 1;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, followed by a
// one-flop history stage that yields single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability filter plus previous-value stage for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank for the RSA core: oversamples the SPI
// pins in the clk domain, decodes command/data frames, holds the RSA
// operand registers, emits start/stop pulses and captures the result.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             spi_cs_n,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_start_cmd,
  output logic             spi_stop_cmd,
  output logic [WIDTH-1:0] rsa_p,
  output logic [WIDTH-1:0] rsa_e,
  output logic [WIDTH-1:0] rsa_m,
  output logic [WIDTH-1:0] rsa_const,
  input  logic [WIDTH-1:0] rsa_c,
  input  logic             rsa_eoc,
  input  logic [WIDTH-1:0] status,
  output logic [WIDTH-1:0] spare
);

  // Bit counter must reach the longer of the command and data phases.
  localparam int MAX_BITS = (WIDTH > CMD_BITS) ? WIDTH : CMD_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS);

  localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(WIDTH - 1);

  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADDR_STATUS);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ADDR_CTRL);
  localparam logic [ADDR_W-1:0] A_P      = ADDR_W'(ADDR_P);
  localparam logic [ADDR_W-1:0] A_E      = ADDR_W'(ADDR_E);
  localparam logic [ADDR_W-1:0] A_M      = ADDR_W'(ADDR_M);
  localparam logic [ADDR_W-1:0] A_CONST  = ADDR_W'(ADDR_CONST);
  localparam logic [ADDR_W-1:0] A_C      = ADDR_W'(ADDR_C);
  localparam logic [ADDR_W-1:0] A_SPARE  = ADDR_W'(ADDR_SPARE);

  // Synchronised pins and edge strobes
  logic w_cs_n_s, w_cs_rise, w_cs_fall;
  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_mosi_s, w_mosi_rise, w_mosi_fall;

  // Sequencer
  state_t r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_write;
  logic [ADDR_W-2:0] r_addr_sr;   // trailing command bits; the final bit completes the address
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_data_sr;

  // Sequencer control strobes
  logic w_cnt_clr, w_cnt_inc, w_rw_latch, w_addr_shift, w_cmd_done;
  logic w_wr_shift, w_rd_shift, w_commit;

  // Register file
  logic [WIDTH-1:0] r_p, r_e, r_m, r_const, r_c, r_spare;
  logic             r_start, r_stop;

  logic [ADDR_W-1:0] w_cmd_addr;
  logic [WIDTH-1:0]  w_wr_data;
  logic              w_unused_edges;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rstb   (rstb),
    .i_async(spi_cs_n),
    .o_sync (w_cs_n_s),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rstb   (rstb),
    .i_async(spi_clk),
    .o_sync (w_sclk_s),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rstb   (rstb),
    .i_async(spi_mosi),
    .o_sync (w_mosi_s),
    .o_rise (w_mosi_rise),
    .o_fall (w_mosi_fall)
  );

  // The cs_n level (not its edge) aborts frames, so a rise missed while
  // ena was low still returns the sequencer to IDLE.
  assign w_unused_edges = w_cs_rise ^ w_sclk_s ^ w_mosi_rise ^ w_mosi_fall;

  // Address completes with the bit arriving on the 8th rising edge.
  assign w_cmd_addr = {r_addr_sr, w_mosi_s};
  // Write data completes with the bit arriving on the last rising edge.
  assign w_wr_data  = {r_data_sr[WIDTH-2:0], w_mosi_s};

  // Value returned for a read of the given address (pre-update snapshot).
  function automatic logic [WIDTH-1:0] read_mux(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    case (a)
      A_STATUS: v = status;
      A_P:      v = r_p;
      A_E:      v = r_e;
      A_M:      v = r_m;
      A_CONST:  v = r_const;
      A_C:      v = r_c;
      A_SPARE:  v = r_spare;
      default:  v = '0;   // control register and unmapped addresses
    endcase
    return v;
  endfunction

  // Sequencer state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and control strobes; everything freezes while ena is low.
  // NOTE: every output of this block gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_rw_latch   = 1'b0;
    w_addr_shift = 1'b0;
    w_cmd_done   = 1'b0;
    w_wr_shift   = 1'b0;
    w_rd_shift   = 1'b0;
    w_commit     = 1'b0;
    if (ena) begin
      if (r_state != IDLE && w_cs_n_s) begin
        w_next_state = IDLE;            // deselect discards a partial frame
      end else begin
        case (r_state)
          IDLE: begin
            if (w_cs_fall) begin
              w_next_state = CMD;
              w_cnt_clr    = 1'b1;
            end
          end
          CMD: begin
            if (w_sclk_rise) begin
              w_addr_shift = 1'b1;
              w_cnt_inc    = 1'b1;
              if (r_cnt == '0) w_rw_latch = 1'b1;   // first bit is R/W
              if (r_cnt == CNT_CMD_LAST) begin
                w_cmd_done   = 1'b1;
                w_cnt_clr    = 1'b1;
                w_next_state = DATA;
              end
            end
          end
          DATA: begin
            if (w_sclk_rise) begin
              w_cnt_inc  = 1'b1;
              w_wr_shift = r_is_write;
              if (r_cnt == CNT_DATA_LAST) begin
                w_commit     = r_is_write;
                w_next_state = DONE;
              end
            end
            // The falling edge right after the command byte must not shift:
            // the master has not yet sampled the MSB.
            if (w_sclk_fall && !r_is_write && r_cnt != '0) w_rd_shift = 1'b1;
          end
          DONE:    w_next_state = DONE;
          default: w_next_state = IDLE;
        endcase
      end
    end
  end

  // Bit counter, command capture and the shared data shift register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_addr_sr  <= '0;
      r_addr     <= '0;
      r_data_sr  <= '0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;

      if (w_rw_latch)   r_is_write <= w_mosi_s;
      if (w_addr_shift) r_addr_sr  <= w_cmd_addr[ADDR_W-2:0];

      if (w_cmd_done) begin
        r_addr    <= w_cmd_addr;
        r_data_sr <= r_is_write ? '0 : read_mux(w_cmd_addr);
      end else if (w_wr_shift) begin
        r_data_sr <= w_wr_data;
      end else if (w_rd_shift) begin
        r_data_sr <= {r_data_sr[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Writable registers and the self-clearing control pulses.
  // NOTE: these are a handful of flops, not a RAM, so they take the async
  // reset and come up as zero for the RSA core.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_p     <= '0;
      r_e     <= '0;
      r_m     <= '0;
      r_const <= '0;
      r_spare <= '0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_start <= w_commit && (r_addr == A_CTRL) && w_wr_data[CTRL_START_BIT];
      r_stop  <= w_commit && (r_addr == A_CTRL) && w_wr_data[CTRL_STOP_BIT];
      if (w_commit) begin
        case (r_addr)
          A_STATUS, A_SPARE: r_spare <= w_wr_data;
          A_P:               r_p     <= w_wr_data;
          A_E:               r_e     <= w_wr_data;
          A_M:               r_m     <= w_wr_data;
          A_CONST:           r_const <= w_wr_data;
          default: ;                        // control, C and unmapped: no storage
        endcase
      end
    end
  end

  // Result capture; independent of ena so a finished calculation is never lost.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)        r_c <= '0;
    else if (rsa_eoc) r_c <= rsa_c;
  end

  assign spi_miso      = (r_state == DATA && !r_is_write) ? r_data_sr[WIDTH-1] : 1'b0;
  assign spi_start_cmd = r_start;
  assign spi_stop_cmd  = r_stop;
  assign rsa_p         = r_p;
  assign rsa_e         = r_e;
  assign rsa_m         = r_m;
  assign rsa_const     = r_const;
  assign spare         = r_spare;

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Parametrised SPI-slave register bank that replaces the stubbed SPI wrapper in the RSA top level.
- Receives SPI mode-0 frames, oversampled in the `clk` domain.
- Exposes WIDTH-bit configuration registers (P, E, M, Const) to the RSA core.
- Generates one-cycle start/stop command pulses.
- Captures the RSA result C on end-of-calculation so the host can read it back with status.

Parameters:
- WIDTH, 8: width of every register, of the SPI data phase and of the rsa_* buses.
- ADDR_W, 3: address bits taken from the command byte. Legal range 3..7.

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- ena  in  1  block enable; when low, SPI input is ignored and all registers hold
- spi_cs_n  in  1  SPI chip select, active low, asynchronous
- spi_clk  in  1  SPI clock, mode 0, asynchronous
- spi_mosi  in  1  SPI data in, MSB first
- spi_miso  out  1  SPI data out, MSB first
- spi_start_cmd  out  1  one-clk start pulse to the RSA core
- spi_stop_cmd  out  1  one-clk stop pulse to the RSA core
- rsa_p  out  WIDTH  register 2
- rsa_e  out  WIDTH  register 3
- rsa_m  out  WIDTH  register 4
- rsa_const  out  WIDTH  register 5
- rsa_c  in  WIDTH  RSA result
- rsa_eoc  in  1  one-clk end-of-calculation strobe; loads rsa_c into register 6
- status  in  WIDTH  live status word, read at address 0
- spare  out  WIDTH  register 7

Behaviour:
- Reset (rstb low, asynchronous): every register = 0, FSM = IDLE, spi_miso = 0, start/stop pulses = 0.
- Reset asserted mid-frame aborts the frame; no write occurs.
- Synchroniser: spi_cs_n, spi_clk and spi_mosi each pass through 2 flops, then an edge detector. spi_clk frequency must be ≤ clk/6.
- Frame format: 8-bit command, then WIDTH data bits.
  - Command bit7 = 1 means write, 0 means read.
  - Command bits[ADDR_W-1:0] = address. Remaining bits are ignored.
  - MOSI is sampled on synchronised spi_clk rising edges.
- FSM states:
  - IDLE: wait for cs_n to fall, then go to CMD and clear the bit counter.
  - CMD: shift 8 bits. On the 8th rising edge, latch the command. For a read, load the shift register with the addressed value and go to DATA.
  - DATA: shift WIDTH bits. After the WIDTH-th rising edge, a write commits and the FSM goes to DONE.
  - DONE: ignore further edges until cs_n rises, then go to IDLE.
  - From any state, cs_n rising returns the FSM to IDLE. A partial frame is discarded with no write.
- Read data:
  - Snapshot taken at the end of the command byte.
  - The MSB is driven immediately; the shift register shifts on each synchronised spi_clk falling edge.
  - spi_miso = 0 whenever the FSM is not in DATA with a read command.
- Write commit: the register updates within 4 clk cycles of the final spi_clk rising edge at the pin (2 sync + 1 edge + 1 commit).
- Register map:
  - 0: read = status. Write goes to spare (register 7).
  - 1: control, self-clearing, never stored; reads return 0.
    - Write bit0 = 1: spi_start_cmd pulses high for exactly 1 clk, in the commit cycle.
    - Write bit1 = 1: spi_stop_cmd pulses high for exactly 1 clk.
    - Both bits set: both pulse in the same cycle.
  - 2: P. 3: E. 4: M. 5: Const. All read/write.
  - 6: C, read-only; SPI writes are ignored. rsa_eoc = 1 loads rsa_c on that cycle.
  - 7: spare, read/write.
  - Addresses ≥ 8: reads return 0, writes are ignored.
- Simultaneous events:
  - rsa_eoc coinciding with a read snapshot of address 6: the snapshot takes the pre-update value.
  - rsa_eoc is honoured even while ena = 0.
- ena low mid-frame: the FSM freezes. When ena returns, the frame completes only if cs_n is still low.

Decomposition:
- Package spi_reg_pkg holds:
  - address localparams: ADDR_STATUS=0, ADDR_CTRL=1, ADDR_P=2, ADDR_E=3, ADDR_M=4, ADDR_CONST=5, ADDR_C=6, ADDR_SPARE=7
  - CMD_RW_BIT=7, CTRL_START_BIT=0, CTRL_STOP_BIT=1
  - the FSM state enum {IDLE, CMD, DATA, DONE}
- Sub-module spi_sync_edge: 2-flop synchroniser plus rise/fall detect, instantiated once per SPI input.

Test Plan:
- Write addr2 = 0xA5, then read addr2 → rsa_p = 0xA5 within 4 clk of the last edge; MISO returns 0xA5 MSB first.
- status = 0x5A, read addr0 → 0x5A. Write addr0 = 0x33 → spare = 0x33, status unaffected.
- Write addr1 = 0x03 → spi_start_cmd and spi_stop_cmd are each high for exactly 1 clk; a subsequent read of addr1 → 0x00.
- rsa_c = 0x3C, rsa_eoc pulse → read addr6 returns 0x3C. A later SPI write of 0xFF to addr6 → a read still returns 0x3C.
- Write frame to addr4 aborted (cs_n rises after 5 data bits) → rsa_m unchanged. The next full frame works normally.
- rstb low mid-write to addr5 → all outputs 0. After release, a full write to addr5 = 0x81 succeeds.
